// File: rtl/next_pc_unit_pkg.sv
// ============================================================================
//  Module   : next_pc_unit_pkg
//  Brief    : Exception cause codes, redirect priorities and default vectors
//             shared by the next-PC unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package next_pc_unit_pkg;

  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_SYS  = 5'd8;
  localparam logic [4:0] CAUSE_BP   = 5'd9;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;
  localparam logic [4:0] CAUSE_TRAP = 5'd13;

  // Larger value means higher priority; relational compares rely on this.
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_MISP = 2'd1,
    PRIO_ERET = 2'd2,
    PRIO_EXC  = 2'd3
  } redirect_prio_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_INT_VECTOR = 32'h0000_0020;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0040;

  // Only the interrupt cause goes to the interrupt vector; known and unknown
  // exception causes all share the exception vector.
  function automatic logic is_int_cause(input logic [4:0] cause);
    case (cause)
      CAUSE_INT:                          return 1'b1;
      CAUSE_ADEL, CAUSE_ADES, CAUSE_SYS,
      CAUSE_BP, CAUSE_RI, CAUSE_OV,
      CAUSE_TRAP:                         return 1'b0;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_unit_if.sv
// ============================================================================
//  Module   : next_pc_unit_if
//  Brief    : Redirect-source and fetch-side signal bundle of the next-PC unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface next_pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              i_stall;
  logic              i_answer_exc;
  logic [4:0]        i_MEM_exception_cause;
  logic              i_MEM_is_eret;
  logic [ADDR_W-1:0] i_MEM_epc_value;
  logic              i_ID_valid;
  logic              i_ID_is_branch_jump_instr;
  logic [ADDR_W-1:0] i_ID_pc;
  logic              i_ID_taken;
  logic [ADDR_W-1:0] i_ID_branch_jump_dst_pc;
  logic              i_ID_pred_taken;
  logic [ADDR_W-1:0] i_ID_pred_target;
  logic [ADDR_W-1:0] o_IF_pc;
  logic              o_IF_pred_taken;
  logic [ADDR_W-1:0] o_IF_pred_target;
  logic              o_IF_kill;

  modport slave (
    input  i_stall, i_answer_exc, i_MEM_exception_cause, i_MEM_is_eret,
           i_MEM_epc_value, i_ID_valid, i_ID_is_branch_jump_instr, i_ID_pc,
           i_ID_taken, i_ID_branch_jump_dst_pc, i_ID_pred_taken,
           i_ID_pred_target,
    output o_IF_pc, o_IF_pred_taken, o_IF_pred_target, o_IF_kill
  );

  modport master (
    output i_stall, i_answer_exc, i_MEM_exception_cause, i_MEM_is_eret,
           i_MEM_epc_value, i_ID_valid, i_ID_is_branch_jump_instr, i_ID_pc,
           i_ID_taken, i_ID_branch_jump_dst_pc, i_ID_pred_taken,
           i_ID_pred_target,
    input  o_IF_pc, o_IF_pred_taken, o_IF_pred_target, o_IF_kill
  );
endinterface

`default_nettype wire

// File: rtl/next_pc_unit_branch_target_buffer.sv
// ============================================================================
//  Module   : branch_target_buffer
//  Brief    : Direct-mapped BTB, combinational lookup, single write/invalidate.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_target_buffer #(
  parameter int ADDR_W    = 32,
  parameter int BTB_DEPTH = 16,
  parameter bit BTB_EN    = 1'b1
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic [ADDR_W-1:0] i_rd_pc,
  output logic                   o_rd_hit,
  output logic      [ADDR_W-1:0] o_rd_target,
  input  wire logic              i_wr_en,
  input  wire logic              i_wr_inv,
  input  wire logic [ADDR_W-1:0] i_wr_pc,
  input  wire logic [ADDR_W-1:0] i_wr_target
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [BTB_DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_mem [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_mem [BTB_DEPTH];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_active, inv_active;
  logic             unused_pc_lsbs;

  assign rd_idx         = i_rd_pc[IDX_W+1:2];
  assign rd_tag         = i_rd_pc[ADDR_W-1:IDX_W+2];
  assign wr_idx         = i_wr_pc[IDX_W+1:2];
  assign wr_tag         = i_wr_pc[ADDR_W-1:IDX_W+2];
  assign wr_active      = BTB_EN && i_wr_en;
  assign inv_active     = BTB_EN && i_wr_inv;
  assign unused_pc_lsbs = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  always_comb begin
    valid_d = valid_q;
    if (wr_active) begin
      valid_d[wr_idx] = 1'b1;
    end else if (inv_active) begin
      valid_d[wr_idx] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/target storage is deliberately left out of reset; valid bits gate it.
  always_ff @(posedge i_clk) begin
    if (wr_active) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= i_wr_target;
    end
  end

  assign o_rd_hit    = BTB_EN && valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign o_rd_target = o_rd_hit ? tgt_mem[rd_idx] : '0;

endmodule

`default_nettype wire

// File: rtl/next_pc_unit.sv
// ============================================================================
//  Module   : next_pc_unit
//  Brief    : IF program counter with prioritised redirects, stall-time
//             pending redirect and BTB-based taken-branch prediction.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(DEFAULT_INT_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR),
  parameter int                BTB_DEPTH  = 16,
  parameter bit                BTB_EN     = 1'b1
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst_n,
  next_pc_unit_if.slave  bus
);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  redirect_prio_e    pend_prio_q, pend_prio_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  redirect_prio_e    new_prio;
  logic [ADDR_W-1:0] new_target;
  logic              new_valid, take_new, misp;
  logic              btb_upd, btb_hit;
  logic [ADDR_W-1:0] btb_target;

  assign misp = bus.i_ID_valid && bus.i_ID_is_branch_jump_instr &&
                ((bus.i_ID_taken != bus.i_ID_pred_taken) ||
                 (bus.i_ID_taken && (bus.i_ID_branch_jump_dst_pc != bus.i_ID_pred_target)));

  always_comb begin
    new_prio   = PRIO_NONE;
    new_target = '0;
    if (bus.i_answer_exc) begin
      new_prio   = PRIO_EXC;
      new_target = is_int_cause(bus.i_MEM_exception_cause) ? INT_VECTOR : EXC_VECTOR;
    end else if (bus.i_MEM_is_eret) begin
      new_prio   = PRIO_ERET;
      new_target = bus.i_MEM_epc_value;
    end else if (misp) begin
      new_prio   = PRIO_MISP;
      new_target = bus.i_ID_taken ? bus.i_ID_branch_jump_dst_pc : bus.i_ID_pc + PC_STEP;
    end
  end

  assign new_valid = (new_prio != PRIO_NONE);
  // Ties go to the newer redirect, both when storing and when consuming.
  assign take_new  = new_valid && (!pend_valid_q || (new_prio >= pend_prio_q));

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_prio_d   = pend_prio_q;
    pend_target_d = pend_target_q;
    if (bus.i_stall) begin
      if (take_new) begin
        pend_valid_d  = 1'b1;
        pend_prio_d   = new_prio;
        pend_target_d = new_target;
      end
    end else begin
      pend_valid_d = 1'b0;
      pend_prio_d  = PRIO_NONE;
      if (take_new) begin
        pc_d = new_target;
      end else if (pend_valid_q) begin
        pc_d = pend_target_q;
      end else if (btb_hit) begin
        pc_d = btb_target;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_prio_q   <= PRIO_NONE;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_prio_q   <= pend_prio_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Training follows ID resolution regardless of stall or older redirects.
  assign btb_upd = bus.i_ID_valid && bus.i_ID_is_branch_jump_instr;

  branch_target_buffer #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH),
    .BTB_EN    (BTB_EN)
  ) u_btb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_pc     (pc_q),
    .o_rd_hit    (btb_hit),
    .o_rd_target (btb_target),
    .i_wr_en     (btb_upd && bus.i_ID_taken),
    .i_wr_inv    (btb_upd && !bus.i_ID_taken && bus.i_ID_pred_taken),
    .i_wr_pc     (bus.i_ID_pc),
    .i_wr_target (bus.i_ID_branch_jump_dst_pc)
  );

  assign bus.o_IF_pc          = pc_q;
  assign bus.o_IF_pred_taken  = btb_hit;
  assign bus.o_IF_pred_target = btb_target;
  assign bus.o_IF_kill        = new_valid || pend_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_next_pc_unit.sv
// ============================================================================
//  Module   : tb_next_pc_unit
//  Brief    : Directed and random self-checking bench for next_pc_unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_next_pc_unit;
  localparam int DEPTH = 16;
  localparam int IDXW  = $clog2(DEPTH);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  next_pc_unit_if #(.ADDR_W(32)) bus ();

  next_pc_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0),
    .INT_VECTOR (32'h20),
    .EXC_VECTOR (32'h40),
    .BTB_DEPTH  (DEPTH),
    .BTB_EN     (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: fetch PC, one pending redirect slot, BTB contents.
  logic [31:0] m_pc;
  bit          m_pv;
  int          m_pp;
  logic [31:0] m_pt;
  bit          m_bv   [DEPTH];
  logic [31:0] m_btag [DEPTH];
  logic [31:0] m_btgt [DEPTH];

  logic [31:0] pool [8] = '{32'h80, 32'h84, 32'h100, 32'h200,
                           32'h300, 32'h400, 32'h1234, 32'hFFFF_FFFC};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_pv = 1'b0;
    m_pp = 0;
    m_pt = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_bv[i] = 1'b0;
  endtask

  task automatic set_idle();
    bus.i_stall                   = 1'b0;
    bus.i_answer_exc              = 1'b0;
    bus.i_MEM_exception_cause     = 5'd0;
    bus.i_MEM_is_eret             = 1'b0;
    bus.i_MEM_epc_value           = 32'h0;
    bus.i_ID_valid                = 1'b0;
    bus.i_ID_is_branch_jump_instr = 1'b0;
    bus.i_ID_pc                   = 32'h0;
    bus.i_ID_taken                = 1'b0;
    bus.i_ID_branch_jump_dst_pc   = 32'h0;
    bus.i_ID_pred_taken           = 1'b0;
    bus.i_ID_pred_target          = 32'h0;
  endtask

  // Called at a negedge with inputs applied; checks this cycle's outputs,
  // advances the model across the next posedge and returns at the negedge.
  task automatic tick();
    int          idx, np;
    logic [31:0] tag, ntgt, ptgt;
    bit          hit, bj;
    #1;
    idx  = int'((m_pc >> 2) % DEPTH);
    tag  = m_pc >> (2 + IDXW);
    hit  = m_bv[idx] && (m_btag[idx] == tag);
    ptgt = hit ? m_btgt[idx] : 32'h0;
    bj   = bus.i_ID_valid && bus.i_ID_is_branch_jump_instr;
    np   = 0;
    ntgt = 32'h0;
    if (bus.i_answer_exc) begin
      np   = 3;
      ntgt = (bus.i_MEM_exception_cause == 5'd0) ? 32'h20 : 32'h40;
    end else if (bus.i_MEM_is_eret) begin
      np   = 2;
      ntgt = bus.i_MEM_epc_value;
    end else if (bj && ((bus.i_ID_taken != bus.i_ID_pred_taken) ||
                        (bus.i_ID_taken && bus.i_ID_branch_jump_dst_pc != bus.i_ID_pred_target))) begin
      np   = 1;
      ntgt = bus.i_ID_taken ? bus.i_ID_branch_jump_dst_pc : bus.i_ID_pc + 32'd4;
    end
    check("pc", bus.o_IF_pc, m_pc);
    check("pred_taken", 32'(bus.o_IF_pred_taken), 32'(hit));
    check("pred_target", bus.o_IF_pred_target, ptgt);
    check("kill", 32'(bus.o_IF_kill), 32'((np != 0) || m_pv));
    if (bus.i_stall) begin
      if (np != 0 && (!m_pv || np >= m_pp)) begin
        m_pv = 1'b1;
        m_pp = np;
        m_pt = ntgt;
      end
    end else begin
      if (np != 0 && (!m_pv || np >= m_pp)) m_pc = ntgt;
      else if (m_pv)                        m_pc = m_pt;
      else if (hit)                         m_pc = ptgt;
      else                                  m_pc = m_pc + 32'd4;
      m_pv = 1'b0;
    end
    if (bj) begin
      idx = int'((bus.i_ID_pc >> 2) % DEPTH);
      if (bus.i_ID_taken) begin
        m_bv[idx]   = 1'b1;
        m_btag[idx] = bus.i_ID_pc >> (2 + IDXW);
        m_btgt[idx] = bus.i_ID_branch_jump_dst_pc;
      end else if (bus.i_ID_pred_taken) begin
        m_bv[idx] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic eret_to(input logic [31:0] addr);
    set_idle();
    bus.i_MEM_is_eret   = 1'b1;
    bus.i_MEM_epc_value = addr;
    tick();
    set_idle();
  endtask

  task automatic branch(input logic [31:0] pc, input bit taken, input logic [31:0] dst,
                        input bit ptaken, input logic [31:0] ptgt);
    bus.i_ID_valid                = 1'b1;
    bus.i_ID_is_branch_jump_instr = 1'b1;
    bus.i_ID_pc                   = pc;
    bus.i_ID_taken                = taken;
    bus.i_ID_branch_jump_dst_pc   = dst;
    bus.i_ID_pred_taken           = ptaken;
    bus.i_ID_pred_target          = ptgt;
  endtask

  task automatic random_inputs();
    bus.i_stall                   = ($urandom_range(0, 99) < 30);
    bus.i_answer_exc              = ($urandom_range(0, 99) < 6);
    bus.i_MEM_exception_cause     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    bus.i_MEM_is_eret             = ($urandom_range(0, 99) < 8);
    bus.i_MEM_epc_value           = pool[$urandom_range(0, 7)];
    bus.i_ID_valid                = ($urandom_range(0, 99) < 60);
    bus.i_ID_is_branch_jump_instr = ($urandom_range(0, 99) < 70);
    bus.i_ID_pc                   = pool[$urandom_range(0, 7)];
    bus.i_ID_taken                = 1'($urandom);
    bus.i_ID_branch_jump_dst_pc   = pool[$urandom_range(0, 7)];
    bus.i_ID_pred_taken           = 1'($urandom);
    bus.i_ID_pred_target          = $urandom_range(0, 1) ? bus.i_ID_branch_jump_dst_pc
                                                         : pool[$urandom_range(0, 7)];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    #1;
    check("rst_pc", bus.o_IF_pc, 32'h0);
    check("rst_pred_taken", 32'(bus.o_IF_pred_taken), 32'h0);
    check("rst_pred_target", bus.o_IF_pred_target, 32'h0);
    check("rst_kill", 32'(bus.o_IF_kill), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) tick();
    check("seq_pc_c", bus.o_IF_pc, 32'hC);

    eret_to(32'h100);
    bus.i_answer_exc = 1'b1; bus.i_MEM_exception_cause = 5'd0;  tick();
    check("int_vec", bus.o_IF_pc, 32'h20);
    bus.i_MEM_exception_cause = 5'd5;  tick();
    check("ades_vec", bus.o_IF_pc, 32'h40);
    bus.i_MEM_exception_cause = 5'd31; tick();
    check("unknown_vec", bus.o_IF_pc, 32'h40);

    set_idle();
    bus.i_stall = 1'b1;
    branch(32'h300, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    set_idle(); bus.i_stall = 1'b1; tick();
    bus.i_answer_exc = 1'b1; bus.i_MEM_exception_cause = 5'd5; tick();
    set_idle(); tick();
    check("stall_release_pc", bus.o_IF_pc, 32'h40);
    check("stall_kill_clear", 32'(bus.o_IF_kill), 32'h0);

    eret_to(32'h80);
    branch(32'h80, 1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    set_idle();
    check("misp_taken_pc", bus.o_IF_pc, 32'h400);
    eret_to(32'h80);
    check("btb_hit", 32'(bus.o_IF_pred_taken), 32'h1);
    check("btb_target", bus.o_IF_pred_target, 32'h400);
    tick();
    check("btb_follow", bus.o_IF_pc, 32'h400);
    branch(32'h80, 1'b0, 32'h400, 1'b1, 32'h400);
    tick();
    set_idle();
    check("misp_nt_pc", bus.o_IF_pc, 32'h84);
    eret_to(32'h80);
    check("btb_inval", 32'(bus.o_IF_pred_taken), 32'h0);
    tick();

    bus.i_answer_exc = 1'b1; bus.i_MEM_exception_cause = 5'd4;
    branch(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    set_idle();
    check("exc_over_misp", bus.o_IF_pc, 32'h40);
    eret_to(32'h1234);
    check("eret_pc", bus.o_IF_pc, 32'h1234);
    eret_to(32'hFFFF_FFFC);
    tick();
    check("pc_wrap", bus.o_IF_pc, 32'h0);

    for (int i = 0; i < 500; i++) begin
      random_inputs();
      tick();
    end

    // Reset asserted while a redirect is pending under stall.
    set_idle();
    bus.i_stall = 1'b1;
    branch(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    set_idle();
    bus.i_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midstall_rst_pc", bus.o_IF_pc, 32'h0);
    check("midstall_rst_kill", 32'(bus.o_IF_kill), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_idle();
    tick();
    check("post_rst_pc", bus.o_IF_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
